adder_tree_pipe: RTL and testbench

ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

---
 rtl/adder_pkg.sv | 33 +++
 rtl/adder_tree_pipe_if.sv | 26 ++
 rtl/adder_tree_level.sv | 50 +++++
 rtl/adder_tree_pipe.sv | 53 +++++
 tb/tb_adder_tree_pipe.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree.
// lvl_off() locates each tree level inside one flat bus in the top level.
package adder_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_IN = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic int out_w(input int data_w, input int num_in);
        return data_w + clog2(num_in);
    endfunction

    // Level s holds (num_in >> s) partial sums, each data_w + s bits wide.
    function automatic int lvl_off(input int data_w, input int num_in, input int lvl);
        int off;
        off = 0;
        for (int i = 0; i < lvl; i++) begin
            off = off + (num_in >> i) * (data_w + i);
        end
        return off;
    endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Valid/ready stream bundle between a producer of operand beats and the adder tree.
// The master modport is the upstream side that drives beats and consumes sums.
interface adder_tree_pipe_if #(
    parameter int DATA_W = adder_pkg::DEF_DATA_W,
    parameter int NUM_IN = adder_pkg::DEF_NUM_IN
);
    localparam int OUT_W = adder_pkg::out_w(DATA_W, NUM_IN);

    logic                     data_in_vld;
    logic                     data_in_rdy;
    logic [NUM_IN*DATA_W-1:0] data_in;
    logic                     data_out_vld;
    logic                     data_out_rdy;
    logic [OUT_W-1:0]         data_out;

    modport master (
        output data_in_vld, data_in, data_out_rdy,
        input  data_in_rdy, data_out_vld, data_out
    );

    modport slave (
        input  data_in_vld, data_in, data_out_rdy,
        output data_in_rdy, data_out_vld, data_out
    );

endinterface

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: adds PAIRS adjacent operand pairs, one bit wider.
// Loads only when the shared advance is high, otherwise holds data and valid.
module adder_tree_level #(
    parameter int IN_W   = 8,
    parameter int PAIRS  = 2,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       adv,
    input  logic                       in_vld,
    input  logic [2*PAIRS*IN_W-1:0]    in_data,
    output logic                       out_vld,
    output logic [PAIRS*(IN_W+1)-1:0]  out_data
);

    logic [PAIRS*(IN_W+1)-1:0] sum_d, sum_q;
    logic                      vld_d, vld_q;

    // One guard bit per level keeps the pairwise sum exact for either signedness.
    function automatic logic [IN_W:0] ext(input logic [IN_W-1:0] a);
        return (SIGNED != 0) ? {a[IN_W-1], a} : {1'b0, a};
    endfunction

    always_comb begin
        sum_d = sum_q;
        vld_d = vld_q;
        if (adv) begin
            vld_d = in_vld;
            for (int p = 0; p < PAIRS; p++) begin
                sum_d[p*(IN_W+1) +: (IN_W+1)] = ext(in_data[(2*p)*IN_W +: IN_W])
                                              + ext(in_data[(2*p+1)*IN_W +: IN_W]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            vld_q <= vld_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_data = sum_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree: NUM_IN operands per beat summed over log2(NUM_IN) levels.
// All levels advance together whenever the output register is empty or being drained.
module adder_tree_pipe
    import adder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SIGNED = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_tree_pipe_if.slave   bus
);

    localparam int STAGES = clog2(NUM_IN);
    localparam int OUT_W  = out_w(DATA_W, NUM_IN);
    localparam int BUS_W  = lvl_off(DATA_W, NUM_IN, STAGES + 1);

    // Level 0 is the raw input beat; the last level is the registered result.
    logic [BUS_W-1:0]  tree;
    logic [STAGES:0]   vld;
    logic              adv;

    assign adv              = ~vld[STAGES] | bus.data_out_rdy;
    assign bus.data_in_rdy  = adv;
    assign tree[NUM_IN*DATA_W-1:0] = bus.data_in;
    assign vld[0]           = bus.data_in_vld;

    for (genvar s = 1; s <= STAGES; s++) begin : gen_lvl
        localparam int IW       = DATA_W + s - 1;
        localparam int PAIRS    = NUM_IN >> s;
        localparam int IN_OFF   = lvl_off(DATA_W, NUM_IN, s - 1);
        localparam int OUT_OFF  = lvl_off(DATA_W, NUM_IN, s);

        adder_tree_level #(
            .IN_W   (IW),
            .PAIRS  (PAIRS),
            .SIGNED (SIGNED)
        ) u_level (
            .clk      (clk),
            .rst_n    (rst_n),
            .adv      (adv),
            .in_vld   (vld[s-1]),
            .in_data  (tree[IN_OFF +: 2*PAIRS*IW]),
            .out_vld  (vld[s]),
            .out_data (tree[OUT_OFF +: PAIRS*(IW+1)])
        );
    end

    assign bus.data_out     = tree[BUS_W-1 -: OUT_W];
    assign bus.data_out_vld = vld[STAGES];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: three configurations (4x8 unsigned, 4x8 signed, 16x4 unsigned)
// exercised with fixed vectors, stall/reset sequences and a random vld/rdy scoreboard.
module tb_adder_tree_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    adder_tree_pipe_if #(.DATA_W(8), .NUM_IN(4))  if_a ();
    adder_tree_pipe_if #(.DATA_W(8), .NUM_IN(4))  if_b ();
    adder_tree_pipe_if #(.DATA_W(4), .NUM_IN(16)) if_c ();

    adder_tree_pipe #(.DATA_W(8), .NUM_IN(4),  .SIGNED(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    adder_tree_pipe #(.DATA_W(8), .NUM_IN(4),  .SIGNED(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    adder_tree_pipe #(.DATA_W(4), .NUM_IN(16), .SIGNED(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    typedef struct packed {
        logic [1:0]  d;
        logic [63:0] din;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [13];

    function automatic int nin(input int d);  return (d == 2) ? 16 : 4; endfunction
    function automatic int dw(input int d);   return (d == 2) ? 4 : 8;  endfunction
    function automatic int sgn(input int d);  return (d == 1) ? 1 : 0;  endfunction
    function automatic int stg(input int d);  return (d == 2) ? 4 : 2;  endfunction
    function automatic logic [63:0] mask(input int d);
        return (d == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    // Plain integer sum of the beat's operands, reduced to the output width.
    function automatic logic [15:0] ref_sum(input int d, input logic [63:0] din);
        longint acc;
        longint op;
        logic [63:0] m;
        acc = 0;
        for (int k = 0; k < nin(d); k++) begin
            m  = (din >> (k * dw(d))) & ((64'd1 << dw(d)) - 64'd1);
            op = longint'(m);
            if (sgn(d) != 0 && op >= (longint'(1) << (dw(d) - 1)))
                op = op - (longint'(1) << dw(d));
            acc = acc + op;
        end
        return 16'(acc) & 16'((32'd1 << (dw(d) + stg(d))) - 32'd1);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [63:0] din, input logic ordy);
        case (d)
            0: begin if_a.data_in_vld = v; if_a.data_in = din[31:0]; if_a.data_out_rdy = ordy; end
            1: begin if_b.data_in_vld = v; if_b.data_in = din[31:0]; if_b.data_out_rdy = ordy; end
            default: begin if_c.data_in_vld = v; if_c.data_in = din; if_c.data_out_rdy = ordy; end
        endcase
    endtask

    task automatic sample(input int d, output logic ov, output logic [15:0] od, output logic ir);
        case (d)
            0: begin ov = if_a.data_out_vld; od = 16'(if_a.data_out); ir = if_a.data_in_rdy; end
            1: begin ov = if_b.data_out_vld; od = 16'(if_b.data_out); ir = if_b.data_in_rdy; end
            default: begin ov = if_c.data_out_vld; od = 16'(if_c.data_out); ir = if_c.data_in_rdy; end
        endcase
    endtask

    task automatic single_beat(input int d, input logic [63:0] din, input logic [15:0] exp, input string nm);
        logic ov, ir;
        logic [15:0] od;
        @(negedge clk);
        drive(d, 1'b1, din, 1'b1);
        #1 sample(d, ov, od, ir);
        chk({nm, " in_rdy"}, 16'(ir), 16'd1);
        for (int i = 1; i <= stg(d); i++) begin
            @(negedge clk);
            drive(d, 1'b0, 64'd0, 1'b1);
            #1 sample(d, ov, od, ir);
            if (i < stg(d)) begin
                chk({nm, " early vld"}, 16'(ov), 16'd0);
            end else begin
                chk({nm, " vld"}, 16'(ov), 16'd1);
                chk({nm, " data"}, od, exp);
            end
        end
        @(negedge clk);
        #1 sample(d, ov, od, ir);
        chk({nm, " vld drop"}, 16'(ov), 16'd0);
    endtask

    task automatic rand_run(input int d, input int ncyc, input int vld_pct, input int rdy_pct, input logic allf);
        logic [15:0] q[$];
        logic ov, ir, v, r, held_v;
        logic [15:0] od, held;
        logic [63:0] din;
        held_v = 1'b0;
        held   = 16'd0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            v   = ($urandom_range(99) < vld_pct);
            r   = ($urandom_range(99) < rdy_pct);
            din = allf ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            din = din & mask(d);
            drive(d, v, din, r);
            #1 sample(d, ov, od, ir);
            chk("rdy rule", 16'(ir), 16'(!ov || r));
            if (held_v) begin
                chk("stall vld", 16'(ov), 16'd1);
                chk("stall data", od, held);
            end
            held_v = ov && !r;
            held   = od;
            if (ov && r) begin
                if (q.size() == 0) chk("spurious out", 16'd1, 16'd0);
                else chk("sb data", od, q.pop_front());
            end
            if (v && ir) q.push_back(ref_sum(d, din));
            chk("in flight", 16'(q.size() <= stg(d)), 16'd1);
        end
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            @(negedge clk);
            drive(d, 1'b0, 64'd0, 1'b1);
            #1 sample(d, ov, od, ir);
            if (ov) chk("drain data", od, q.pop_front());
        end
        chk("drain empty", 16'(q.size()), 16'd0);
        @(negedge clk);
        drive(d, 1'b0, 64'd0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic ov, ir, r, saw;
        logic [15:0] od;
        logic [15:0] outs [6];
        int sent, got, stall;

        tbl[0]  = '{2'd0, 64'h0000_0000_0403_0201, 16'd10};
        tbl[1]  = '{2'd0, 64'h0000_0000_FFFF_FFFF, 16'h3FC};
        tbl[2]  = '{2'd0, 64'h0000_0000_0000_0000, 16'd0};
        tbl[3]  = '{2'd0, 64'h0000_0000_0000_00FF, 16'd255};
        tbl[4]  = '{2'd0, 64'h0000_0000_8080_8080, 16'h200};
        tbl[5]  = '{2'd1, 64'h0000_0000_017F_8080, 16'h380};
        tbl[6]  = '{2'd1, 64'h0000_0000_FFFF_FFFF, 16'h3FC};
        tbl[7]  = '{2'd1, 64'h0000_0000_7F7F_7F7F, 16'h1FC};
        tbl[8]  = '{2'd1, 64'h0000_0000_8080_8080, 16'h200};
        tbl[9]  = '{2'd1, 64'h0000_0000_0000_FD05, 16'd2};
        tbl[10] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 16'hF0};
        tbl[11] = '{2'd2, 64'h0000_0000_0000_0001, 16'd1};
        tbl[12] = '{2'd2, 64'h8000_0000_0000_0000, 16'd8};

        for (int d = 0; d < 3; d++) drive(d, 1'b0, 64'd0, 1'b1);
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        for (int d = 0; d < 3; d++) begin
            sample(d, ov, od, ir);
            chk("reset vld", 16'(ov), 16'd0);
            chk("reset data", od, 16'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            sample(d, ov, od, ir);
            chk("post reset rdy", 16'(ir), 16'd1);
        end

        for (int i = 0; i < 13; i++)
            single_beat(int'(tbl[i].d), tbl[i].din, tbl[i].exp, $sformatf("vec%0d", i));

        // eight back-to-back all-ones beats
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(0, c < 8, 64'hFFFF_FFFF, 1'b1);
            #1 sample(0, ov, od, ir);
            if (c < 8) chk("b2b in_rdy", 16'(ir), 16'd1);
            if (c >= 2) begin
                chk("b2b vld", 16'(ov), 16'd1);
                chk("b2b data", od, 16'h3FC);
                if (ov) got++;
            end
        end
        chk("b2b count", 16'(got), 16'd8);
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 1'b1);
        @(negedge clk);

        // six beats with sums 0..5, output stalled for four cycles from the first result
        sent = 0; got = 0; stall = -1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            drive(0, sent < 6, 64'(sent), 1'b1);
            #1 sample(0, ov, od, ir);
            if (ov && stall < 0) stall = 4;
            r = !(stall > 0);
            drive(0, sent < 6, 64'(sent), r);
            #1 sample(0, ov, od, ir);
            if (stall > 0) begin
                chk("stall in_rdy", 16'(ir), 16'd0);
                chk("stall hold", od, 16'd0);
                stall--;
            end
            if (ov && r) begin
                outs[got] = od;
                got++;
            end
            if (sent < 6 && ir) sent++;
        end
        chk("stall count", 16'(got), 16'd6);
        for (int k = 0; k < 6; k++) chk($sformatf("stall order %0d", k), outs[k], 16'(k));
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 1'b1);
        @(negedge clk);

        rand_run(0, 300, 70, 60, 1'b0);
        rand_run(1, 200, 70, 60, 1'b0);
        rand_run(2, 200, 60, 50, 1'b1);
        rand_run(2, 300, 75, 65, 1'b0);

        // reset with two beats in flight
        @(negedge clk);
        drive(0, 1'b1, 64'h0403_0201, 1'b1);
        @(negedge clk);
        drive(0, 1'b1, 64'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 64'd0, 1'b0);
        #1 sample(0, ov, od, ir);
        chk("pre-reset vld", 16'(ov), 16'd1);
        chk("pre-reset data", od, 16'd10);
        #1 rst_n = 1'b0;
        #1 sample(0, ov, od, ir);
        chk("async reset vld", 16'(ov), 16'd0);
        chk("async reset data", od, 16'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 sample(0, ov, od, ir);
        chk("release in_rdy", 16'(ir), 16'd1);
        saw = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drive(0, 1'b0, 64'd0, 1'b1);
            #1 sample(0, ov, od, ir);
            saw = saw | ov;
        end
        chk("no output after reset", 16'(saw), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
